// File: rtl/imm_ext_pipe.sv
// Registered RISC-V immediate generator between decode and execute.
// A two-entry skid buffer (head + skid) keeps in_ready purely registered.
module imm_ext_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    localparam logic [2:0] FMT_I     = 3'b000;
    localparam logic [2:0] FMT_S     = 3'b001;
    localparam logic [2:0] FMT_B     = 3'b010;
    localparam logic [2:0] FMT_J     = 3'b011;
    localparam logic [2:0] FMT_U     = 3'b100;
    localparam logic [2:0] FMT_Z     = 3'b101;
    localparam logic [2:0] FMT_SHAMT = 3'b110;

    // Builds the immediate at 64 bits and truncates, so one set of
    // concatenations serves both XLEN values. Result is {illegal, imm}.
    function automatic logic [XLEN:0] ext_imm(input logic [24:0] instr_hi,
                                              input logic [2:0]  imm_src);
        logic [31:0] ins;
        logic [63:0] wide;
        logic        s;
        logic        ill;
        ins  = {instr_hi, 7'b0000000};
        s    = ins[31];
        ill  = 1'b0;
        wide = 64'd0;
        case (imm_src)
            FMT_I:     wide = {{52{s}}, ins[31:20]};
            FMT_S:     wide = {{52{s}}, ins[31:25], ins[11:7]};
            FMT_B:     wide = {{52{s}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_J:     wide = {{44{s}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            FMT_U:     wide = {{32{s}}, ins[31:12], 12'h000};
            FMT_Z:     wide = {59'd0, ins[19:15]};
            FMT_SHAMT: wide = (XLEN == 64) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
            default: begin
                wide = 64'd0;
                ill  = 1'b1;
            end
        endcase
        return {ill, wide[XLEN-1:0]};
    endfunction

    state_t            state_r;
    logic [XLEN-1:0]   head_imm_r;
    logic [TAG_W-1:0]  head_tag_r;
    logic              head_ill_r;
    logic [XLEN-1:0]   skid_imm_r;
    logic [TAG_W-1:0]  skid_tag_r;
    logic              skid_ill_r;
    logic              out_valid_r;
    logic              in_ready_r;

    logic              accept_s;
    logic              pop_s;
    logic [XLEN-1:0]   new_imm_s;
    logic              new_ill_s;

    // Handshake qualifiers and extension of the incoming instruction.
    always_comb begin
        accept_s  = 1'b0;
        pop_s     = 1'b0;
        new_imm_s = '0;
        new_ill_s = 1'b0;
        accept_s  = in_valid & in_ready_r;
        pop_s     = out_valid_r & out_ready;
        {new_ill_s, new_imm_s} = ext_imm(in_instr, in_imm_src);
    end

    // Occupancy FSM; data registers only load on the moves that target them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            head_imm_r  <= '0;
            head_tag_r  <= '0;
            head_ill_r  <= 1'b0;
            skid_imm_r  <= '0;
            skid_tag_r  <= '0;
            skid_ill_r  <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (flush) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_imm_r  <= new_imm_s;
                        head_tag_r  <= in_tag;
                        head_ill_r  <= new_ill_s;
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && pop_s) begin
                        head_imm_r <= new_imm_s;
                        head_tag_r <= in_tag;
                        head_ill_r <= new_ill_s;
                    end else if (accept_s) begin
                        skid_imm_r <= new_imm_s;
                        skid_tag_r <= in_tag;
                        skid_ill_r <= new_ill_s;
                        state_r    <= ST_FULL;
                        in_ready_r <= 1'b0;
                    end else if (pop_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        head_imm_r <= skid_imm_r;
                        head_tag_r <= skid_tag_r;
                        head_ill_r <= skid_ill_r;
                        state_r    <= ST_ONE;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_imm     = head_imm_r;
    assign out_tag     = head_tag_r;
    assign out_illegal = head_ill_r;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench: drives XLEN=32 and XLEN=64 instances in lockstep and
// checks every output against a queue of expected results.
module tb_imm_ext_pipe;

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [24:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic [4:0]  a_out_tag;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;
    logic [4:0]  b_out_tag;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t pend;

    imm_ext_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_imm(a_out_imm),
        .out_tag(a_out_tag), .out_illegal(a_out_illegal)
    );

    imm_ext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_imm(b_out_imm),
        .out_tag(b_out_tag), .out_illegal(b_out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference extension using signed casts on the spec's bit fields.
    function automatic logic [63:0] model(input logic [31:0] i, input logic [2:0] src, input bit x64);
        case (src)
            3'd0: model = longint'($signed(i[31:20]));
            3'd1: model = longint'($signed({i[31:25], i[11:7]}));
            3'd2: model = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd3: model = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'd4: model = longint'($signed({i[31:12], 12'h000}));
            3'd5: model = {59'd0, i[19:15]};
            3'd6: model = x64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
            default: model = 64'd0;
        endcase
    endfunction

    task automatic drive_exp(input logic [31:0] instr, input logic [2:0] src, input logic [4:0] tag,
                             input logic [31:0] e32, input logic [63:0] e64);
        in_valid   = 1'b1;
        in_instr   = instr[31:7];
        in_imm_src = src;
        in_tag     = tag;
        pend.imm32 = e32;
        pend.imm64 = e64;
        pend.tag   = tag;
        pend.ill   = (src == 3'd7);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [2:0] src, input logic [4:0] tag);
        logic [63:0] m32;
        m32 = model(instr, src, 1'b0);
        drive_exp(instr, src, tag, m32[31:0], model(instr, src, 1'b1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Called at a negedge: check outputs, update scoreboard, advance one cycle.
    task automatic cyc();
        bit acc;
        bit pop;
        chk("out_valid32", {63'd0, a_out_valid}, {63'd0, (q.size() != 0)});
        chk("out_valid64", {63'd0, b_out_valid}, {63'd0, (q.size() != 0)});
        chk("in_ready32", {63'd0, a_in_ready}, {63'd0, (q.size() < 2)});
        chk("in_ready64", {63'd0, b_in_ready}, {63'd0, (q.size() < 2)});
        if (q.size() != 0) begin
            chk("imm32", {32'd0, a_out_imm}, {32'd0, q[0].imm32});
            chk("imm64", b_out_imm, q[0].imm64);
            chk("tag32", {59'd0, a_out_tag}, {59'd0, q[0].tag});
            chk("tag64", {59'd0, b_out_tag}, {59'd0, q[0].tag});
            chk("ill32", {63'd0, a_out_illegal}, {63'd0, q[0].ill});
            chk("ill64", {63'd0, b_out_illegal}, {63'd0, q[0].ill});
        end
        acc = in_valid && (q.size() < 2);
        pop = (q.size() != 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(pend);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid32"}, {63'd0, a_out_valid}, 64'd0);
        chk({name, "_valid64"}, {63'd0, b_out_valid}, 64'd0);
        chk({name, "_ready32"}, {63'd0, a_in_ready}, 64'd1);
        chk({name, "_ready64"}, {63'd0, b_in_ready}, 64'd1);
        chk({name, "_imm32"}, {32'd0, a_out_imm}, 64'd0);
        chk({name, "_imm64"}, b_out_imm, 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        in_instr   = 25'h1ABCDE;
        in_imm_src = 3'd0;
        in_tag     = 5'd9;
        out_ready  = 1'b1;
        pend       = '{imm32: 32'd0, imm64: 64'd0, tag: 5'd0, ill: 1'b0};

        // Reset held with in_valid high
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk_reset_outputs("reset");
            chk("reset_tag32", {59'd0, a_out_tag}, 64'd0);
            chk("reset_ill64", {63'd0, b_out_illegal}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Directed formats, out_ready=1
        drive_exp(32'hFFF00093, 3'd0, 5'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF); cyc();
        drive_exp(32'hFE000EE3, 3'd2, 5'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC); cyc();
        drive_exp(32'h123450B7, 3'd4, 5'd3, 32'h12345000, 64'h0000000012345000); cyc();
        drive_exp(32'h000FD073, 3'd5, 5'd4, 32'h0000001F, 64'h000000000000001F); cyc();
        drive_exp(32'h800000B7, 3'd4, 5'd5, 32'h80000000, 64'hFFFFFFFF80000000); cyc();
        drive_exp(32'h03F00013, 3'd6, 5'd6, 32'h0000001F, 64'h000000000000003F); cyc();
        drive_exp(32'hFFFFFFFF, 3'd7, 5'd7, 32'h00000000, 64'h0000000000000000); cyc();
        drive_exp(32'h8000_0F80, 3'd1, 5'd8, 32'hFFFFF81F, 64'hFFFFFFFFFFFFF81F); cyc();
        drive_exp(32'h8000_0000, 3'd3, 5'd9, 32'hFFF00000, 64'hFFFFFFFFFFF00000); cyc();
        idle(); cyc(); cyc();

        // Backpressure: tags 1,2,3 back-to-back with execute stalled
        out_ready = 1'b0;
        drive(32'h12345678, 3'd0, 5'd1); cyc();
        drive(32'h9ABCDEF0, 3'd1, 5'd2); cyc();
        drive(32'h0F0F0F0F, 3'd3, 5'd3);
        repeat (3) cyc();
        out_ready = 1'b1;
        cyc();
        cyc();
        idle(); cyc(); cyc();

        // Accept and pop together in ONE
        out_ready = 1'b0;
        drive(32'hCAFEBABE, 3'd2, 5'd6); cyc();
        out_ready = 1'b1;
        drive(32'hDEADBEEF, 3'd4, 5'd7); cyc();
        idle(); cyc(); cyc();

        // Flush while FULL with in_valid and out_ready high
        out_ready = 1'b0;
        drive(32'h11111111, 3'd0, 5'd8); cyc();
        drive(32'h22222222, 3'd1, 5'd9); cyc();
        flush = 1'b1;
        out_ready = 1'b1;
        drive(32'h33333333, 3'd2, 5'd10); cyc();
        flush = 1'b0;
        idle(); cyc();
        drive(32'h44444444, 3'd5, 5'd11); cyc();
        idle(); cyc(); cyc();

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) != 0)
                drive($urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            else
                idle();
            cyc();
        end
        flush = 1'b0;

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        drive(32'h55555555, 3'd0, 5'd20); cyc();
        drive(32'h66666666, 3'd0, 5'd21); cyc();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(32'h77777777, 3'd6, 5'd22); cyc();
        idle(); cyc();

        // Drain with a bounded budget
        out_ready = 1'b1;
        idle();
        for (int k = 0; k < 10 && q.size() != 0; k++) cyc();
        chk("drain_empty", 64'(q.size()), 64'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
